adc_spi_master: RTL and testbench

//  SPI master (mode 0) serving the AD7903 conversion controller. Accepts a one-cycle start,

---
 rtl/adc_spi_pkg.sv | 19 +
 rtl/spi_sclk_gen.sv | 47 ++++
 rtl/adc_spi_master.sv | 88 ++++++++
 tb/tb_adc_spi_master.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared SPI state codes for the AD7903 readout path; the ADC sequencer
// compares against SPI_DONE rather than a literal.
package adc_spi_pkg;

  localparam logic [2:0] SPI_IDLE  = 3'd0;
  localparam logic [2:0] SPI_SETUP = 3'd1;
  localparam logic [2:0] SPI_XFER  = 3'd2;
  localparam logic [2:0] SPI_QUIET = 3'd3;
  localparam logic [2:0] SPI_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = SPI_IDLE,
    ST_SETUP = SPI_SETUP,
    ST_XFER  = SPI_XFER,
    ST_QUIET = SPI_QUIET,
    ST_DONE  = SPI_DONE
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator for mode 0: idle low, first half-period low, rise/fall
// strobes fire in the i_clk cycle before the registered sclk toggles.
module spi_sclk_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int SCLK_HALF  = 3
) (
  input  logic i_clk,
  input  logic i_fRST,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic last
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int EW = $clog2(2 * DATA_WIDTH);

  logic [HW-1:0] half_q;
  logic [EW-1:0] hp_q;
  logic          tick;

  assign tick = en && (half_q == HW'(SCLK_HALF - 1));
  assign rise = tick && !sclk;
  assign fall = tick && sclk;
  // final falling edge closes the transfer
  assign last = fall && (hp_q == EW'(2 * DATA_WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_fRST) begin
    if (!i_fRST) begin
      half_q <= '0;
      hp_q   <= '0;
      sclk   <= 1'b0;
    end else if (!en) begin
      half_q <= '0;
      hp_q   <= '0;
      sclk   <= 1'b0;
    end else begin
      half_q <= tick ? '0 : half_q + 1'b1;
      if (tick) begin
        hp_q <= hp_q + 1'b1;
        sclk <= !sclk;
      end
    end
  end

endmodule

// File: rtl/adc_spi_master.sv
// Mode-0 SPI master reading one AD7903 word per start; FSM and shifters here,
// SCLK timing in spi_sclk_gen.
module adc_spi_master
  import adc_spi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SCLK_HALF  = 3,
  parameter int CS_SETUP   = 2,
  parameter int CS_QUIET   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_fRST,
  input  logic                  i_spi_start,
  input  logic [DATA_WIDTH-1:0] i_spi_data,
  output logic [2:0]            o_spi_state,
  output logic [DATA_WIDTH-1:0] o_spi_rx_data,
  output logic                  o_spi_rx_valid,
  output logic                  o_sclk,
  output logic                  o_mosi,
  input  logic                  i_miso,
  output logic                  o_cs_n
);

  localparam int CW = $clog2(((CS_SETUP > CS_QUIET) ? CS_SETUP : CS_QUIET) + 1);

  spi_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] tx_q, rx_q, rx_data_q;
  logic                  cs_n_q, rx_valid_q;
  logic                  sclk, rise, fall, last;

  spi_sclk_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .SCLK_HALF (SCLK_HALF)
  ) u_sclk (
    .i_clk (i_clk),
    .i_fRST(i_fRST),
    .en    (state_q == ST_XFER),
    .sclk  (sclk),
    .rise  (rise),
    .fall  (fall),
    .last  (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_spi_start) state_d = ST_SETUP;
      ST_SETUP: if (cnt_q == CW'(CS_SETUP - 1)) state_d = ST_XFER;
      ST_XFER:  if (last) state_d = ST_QUIET;
      ST_QUIET: if (cnt_q == CW'(CS_QUIET - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_fRST) begin
    if (!i_fRST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      // outputs registered from next state so they line up with o_spi_state
      cs_n_q     <= !(state_d inside {ST_SETUP, ST_XFER});
      rx_valid_q <= (state_d == ST_DONE);
      if (state_d == ST_DONE) rx_data_q <= rx_q;
      // TX MSB is the MOSI flop; clearing it outside the frame parks MOSI low
      if (state_q == ST_IDLE && i_spi_start) tx_q <= i_spi_data;
      else if (!(state_d inside {ST_SETUP, ST_XFER})) tx_q <= '0;
      else if (fall) tx_q <= tx_q << 1;
      if (rise) rx_q <= {rx_q[DATA_WIDTH-2:0], i_miso};
    end
  end

  assign o_spi_state    = state_q;
  assign o_spi_rx_data  = rx_data_q;
  assign o_spi_rx_valid = rx_valid_q;
  assign o_sclk         = sclk;
  assign o_mosi         = tx_q[DATA_WIDTH-1];
  assign o_cs_n         = cs_n_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: offset-based timing model checked every cycle,
// plus directed literal checks on latency, data and edge counts.
module tb_adc_spi_master;

  localparam int DW  = 16;
  localparam int SH  = 3;
  localparam int CSS = 2;
  localparam int CSQ = 2;
  localparam int XF  = 2 * DW * SH;
  localparam int LAT = CSS + XF + CSQ;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] data = '0;
  logic [2:0]    state;
  logic [DW-1:0] rx;
  logic          rxv, sclk, mosi, miso, cs_n;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  adc_spi_master #(
    .DATA_WIDTH(DW), .SCLK_HALF(SH), .CS_SETUP(CSS), .CS_QUIET(CSQ)
  ) dut (
    .i_clk(clk), .i_fRST(rst_n), .i_spi_start(start), .i_spi_data(data),
    .o_spi_state(state), .o_spi_rx_data(rx), .o_spi_rx_valid(rxv),
    .o_sclk(sclk), .o_mosi(mosi), .i_miso(miso), .o_cs_n(cs_n)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ADC slave: loads word on CS_n fall, SDO advances on SCLK falling edge
  logic [DW-1:0] adc_word = '0;
  logic [DW-1:0] sdo_sr = '0;
  always @(negedge cs_n) sdo_sr = adc_word;
  always @(negedge sclk) if (!cs_n) sdo_sr = sdo_sr << 1;
  assign miso = sdo_sr[DW-1];

  // bus monitors
  int            rcnt = 0;
  int            vcnt = 0;
  logic [DW-1:0] mbits = '0;
  always @(posedge sclk) begin
    rcnt++;
    mbits = {mbits[DW-2:0], mosi};
  end
  always @(negedge clk) if (rxv) vcnt++;

  // model: a transfer accepted at edge e shows state by offset d = edge - e
  int            cyc = 0, e = 0;
  bit            busy = 1'b0, idle_now;
  logic [DW-1:0] m_tx = '0, m_word = '0, m_rx = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 1'b0;
      m_rx = '0;
    end else begin
      idle_now = !busy || (cyc - e > LAT);
      cyc++;
      if (idle_now && start) begin
        busy   = 1'b1;
        e      = cyc;
        m_tx   = data;
        m_word = adc_word;
      end else if (busy && cyc - e == LAT) begin
        m_rx = m_word;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int d, x;
    logic [2:0]    es;
    logic          ecs, esc, emo, ev;
    logic [DW-1:0] t;
    if (cmp_en) begin
      d = cyc - e;
      es = 3'd0; ecs = 1'b1; esc = 1'b0; emo = 1'b0; ev = 1'b0;
      if (busy && d <= LAT) begin
        if (d < CSS) begin
          es = 3'd1; ecs = 1'b0; emo = m_tx[DW-1];
        end else if (d < CSS + XF) begin
          x   = d - CSS;
          es  = 3'd2;
          ecs = 1'b0;
          esc = ((x / SH) % 2) != 0;
          t   = m_tx << (x / (2 * SH));
          emo = t[DW-1];
        end else if (d < LAT) begin
          es = 3'd3;
        end else begin
          es = 3'd4; ev = 1'b1;
        end
      end
      chk("state",    32'(state), 32'(es));
      chk("cs_n",     32'(cs_n),  32'(ecs));
      chk("sclk",     32'(sclk),  32'(esc));
      chk("mosi",     32'(mosi),  32'(emo));
      chk("rx_valid", 32'(rxv),   32'(ev));
      chk("rx_data",  32'(rx),    32'(m_rx));
    end
  end

  // start a transfer; optional one-cycle extra start pulses; returns edges to DONE
  task automatic run(input int pa, input int pb, input bit hold, output int edges);
    edges = 0;
    start = 1'b1;
    while (edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      #1;
      if (edges == 1) data = ~data;
      start = hold || edges == pa || edges == pb;
      if (state == 3'd4) return;
    end
    chk("done_timeout", 32'(edges), 32'(0));
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ed, v0;
    data     = 16'hC3F0;
    adc_word = 16'hA55A;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    repeat (50) @(negedge clk);
    #1;
    chk("idle_state",  32'(state), 32'(0));
    chk("idle_cs_n",   32'(cs_n),  32'(1));
    chk("idle_sclk",   32'(sclk),  32'(0));
    chk("idle_no_vld", 32'(vcnt),  32'(0));

    // single transfer, extra starts ignored, TX data changed after acceptance
    rcnt = 0; v0 = vcnt;
    run(5, 60, 1'b0, ed);
    chk("lat_a55a", 32'(ed), 32'(101));
    chk("rx_a55a",  32'(rx), 32'(16'hA55A));
    @(negedge clk); #1;
    chk("vld_once_a55a", 32'(vcnt - v0), 32'(1));
    chk("rises_a55a",    32'(rcnt),      32'(16));
    chk("mosi_c3f0",     32'(mbits),     32'(16'hC3F0));

    // reset mid-transfer while SCLK is high
    adc_word = 16'h0FF0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk); #1 start = 1'b0;
    repeat (41) @(posedge clk);
    @(negedge clk); #1;
    chk("pre_rst_cs_n", 32'(cs_n), 32'(0));
    chk("pre_rst_sclk", 32'(sclk), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cs_n",  32'(cs_n),  32'(1));
    chk("rst_sclk",  32'(sclk),  32'(0));
    chk("rst_state", 32'(state), 32'(0));
    @(negedge clk); #1 rst_n = 1'b1;
    v0 = vcnt;
    repeat (150) @(negedge clk);
    #1;
    chk("rst_no_done", 32'(vcnt - v0), 32'(0));
    chk("rst_rx_zero", 32'(rx),        32'(0));

    // fresh transfer after reset, boundary bit patterns
    data = 16'h8001; adc_word = 16'h7FFE; rcnt = 0;
    run(0, 0, 1'b0, ed);
    chk("lat_7ffe",   32'(ed),    32'(101));
    chk("rx_7ffe",    32'(rx),    32'(16'h7FFE));
    chk("mosi_8001",  32'(mbits), 32'(16'h8001));
    chk("rises_7ffe", 32'(rcnt),  32'(16));

    // back-to-back with start held high
    repeat (5) @(negedge clk);
    #1 data = 16'h5A5A; adc_word = 16'h3C96; v0 = vcnt;
    run(0, 0, 1'b1, ed);
    chk("b2b_lat1", 32'(ed), 32'(101));
    chk("b2b_rx1",  32'(rx), 32'(16'h3C96));
    adc_word = 16'hE71B;
    run(0, 0, 1'b1, ed);
    start = 1'b0;
    chk("b2b_lat2", 32'(ed), 32'(102));
    chk("b2b_rx2",  32'(rx), 32'(16'hE71B));
    repeat (10) @(negedge clk);
    #1;
    chk("b2b_vld2",  32'(vcnt - v0), 32'(2));
    chk("end_state", 32'(state),     32'(0));

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
